// File: rtl/wb_arb_pkg.sv
`default_nettype none
// ============================================================================
//  Module   : wb_arb_pkg
//  Purpose  : Shared types and constants for the two-master Wishbone arbiter
//             and its bus-timeout watchdog.
//  Revision : 1.0  initial release
// ============================================================================
package wb_arb_pkg;

    // Arbiter FSM encoding; gnt_o is a one-hot decode of these values.
    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_GNT0 = 2'd1,
        ST_GNT1 = 2'd2
    } arb_state_e;

    // Master indices: 0 is the 68k CPU bridge, 1 is the DMA engine.
    localparam int c_M_CPU = 0;
    localparam int c_M_DMA = 1;

    // Default watchdog settings: 255 unterminated strobe cycles, 8-bit counter.
    localparam int c_TIMEOUT_CYCLES_DEF = 255;
    localparam int c_TIMEOUT_W_DEF      = 8;

    // One-hot grant vector for a given arbiter state; IDLE maps to 2'b00.
    function automatic logic [1:0] f_gnt_onehot(input arb_state_e st);
        logic [1:0] v;
        case (st)
            ST_GNT0: v = 2'b01;
            ST_GNT1: v = 2'b10;
            default: v = 2'b00;
        endcase
        return v;
    endfunction

endpackage : wb_arb_pkg
`default_nettype wire

// File: rtl/wb_bus_timeout.sv
`default_nettype none
// ============================================================================
//  Module   : wb_bus_timeout
//  Purpose  : Wishbone strobe watchdog. Counts consecutive strobe cycles that
//             receive neither ACK nor ERR and flags the TIMEOUT_CYCLES-th one.
//             Usable on any single-master bus segment as well.
//  Revision : 1.0  initial release
// ============================================================================
module wb_bus_timeout
    import wb_arb_pkg::*;
#(
    parameter int TIMEOUT_CYCLES = c_TIMEOUT_CYCLES_DEF,  // 0 disables the watchdog
    parameter int TIMEOUT_W      = c_TIMEOUT_W_DEF
) (
    input  logic clk,
    input  logic rst,
    input  logic i_stb,      // strobe currently presented to the slave
    input  logic i_ack,      // slave ACK
    input  logic i_err,      // slave ERR
    output logic o_tmo_hit   // this strobe cycle is the expiry cycle
);

    logic [TIMEOUT_W-1:0] r_count_q;
    logic [TIMEOUT_W-1:0] w_count_d;
    logic                 w_stall;

    // A stalled cycle is a strobe that the slave leaves unterminated.
    assign w_stall = i_stb & ~i_ack & ~i_err;

    generate
        if (TIMEOUT_CYCLES == 0) begin : g_wdog_off
            assign o_tmo_hit = 1'b0;
        end else begin : g_wdog_on
            // The count equals the number of stalled cycles already seen, so
            // the expiry cycle is the one entered with TIMEOUT_CYCLES-1 behind it.
            localparam logic [TIMEOUT_W-1:0] c_LAST = TIMEOUT_W'(TIMEOUT_CYCLES - 1);
            assign o_tmo_hit = w_stall & (r_count_q == c_LAST);
        end
    endgenerate

    // Next count: restart on any termination, idle strobe or expiry; else
    // count up, holding at all-ones so a disabled watchdog never wraps.
    always_comb begin
        w_count_d = r_count_q;
        if (!w_stall || o_tmo_hit) begin
            w_count_d = '0;
        end else if (r_count_q != '1) begin
            w_count_d = r_count_q + 1'b1;
        end
    end

    // Counter register.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_count_q <= '0;
        end else begin
            r_count_q <= w_count_d;
        end
    end

endmodule : wb_bus_timeout
`default_nettype wire

// File: rtl/wb_master_arbiter.sv
`default_nettype none
// ============================================================================
//  Module   : wb_master_arbiter
//  Purpose  : Two-master Wishbone B3 arbiter. Round-robin grant held for the
//             whole CYC, granted master muxed onto the slave bus, stalled
//             strobes terminated with ERR by a bus-timeout watchdog.
//  Revision : 1.0  initial release
// ============================================================================
module wb_master_arbiter
    import wb_arb_pkg::*;
#(
    parameter int TIMEOUT_CYCLES = c_TIMEOUT_CYCLES_DEF,
    parameter int TIMEOUT_W      = c_TIMEOUT_W_DEF
) (
    input  logic        wb_clk_i,
    input  logic        wb_rst_i,
    // master 0 : 68k CPU bridge
    input  logic        m0_cyc_i,
    input  logic        m0_stb_i,
    input  logic        m0_we_i,
    input  logic [3:0]  m0_sel_i,
    input  logic [31:0] m0_adr_i,
    input  logic [31:0] m0_dat_i,
    output logic [31:0] m0_dat_o,
    output logic        m0_ack_o,
    output logic        m0_err_o,
    // master 1 : DMA engine
    input  logic        m1_cyc_i,
    input  logic        m1_stb_i,
    input  logic        m1_we_i,
    input  logic [3:0]  m1_sel_i,
    input  logic [31:0] m1_adr_i,
    input  logic [31:0] m1_dat_i,
    output logic [31:0] m1_dat_o,
    output logic        m1_ack_o,
    output logic        m1_err_o,
    // shared slave side
    output logic        s_cyc_o,
    output logic        s_stb_o,
    output logic        s_we_o,
    output logic [3:0]  s_sel_o,
    output logic [31:0] s_adr_o,
    output logic [31:0] s_dat_o,
    input  logic [31:0] s_dat_i,
    input  logic        s_ack_i,
    input  logic        s_err_i,
    // status
    output logic [1:0]  gnt_o,
    output logic        tmo_o
);

    arb_state_e r_state_q;
    arb_state_e w_state_d;
    logic       r_last_grant_q;   // index of the master that owned the bus last
    logic       w_last_grant_d;
    logic       w_own0;
    logic       w_own1;
    logic       w_tmo_hit;

    // Next-state logic: round-robin from IDLE, hold while the owner keeps CYC,
    // and always pass through IDLE between owners.
    always_comb begin
        w_state_d      = r_state_q;
        w_last_grant_d = r_last_grant_q;
        case (r_state_q)
            ST_IDLE: begin
                if (m0_cyc_i && m1_cyc_i) begin
                    // Tie goes to whichever master did not own the bus last.
                    w_state_d = (r_last_grant_q == 1'(c_M_CPU)) ? ST_GNT1 : ST_GNT0;
                end else if (m0_cyc_i) begin
                    w_state_d = ST_GNT0;
                end else if (m1_cyc_i) begin
                    w_state_d = ST_GNT1;
                end
            end
            ST_GNT0: begin
                if (!m0_cyc_i) begin
                    w_state_d      = ST_IDLE;
                    w_last_grant_d = 1'(c_M_CPU);
                end
            end
            ST_GNT1: begin
                if (!m1_cyc_i) begin
                    w_state_d      = ST_IDLE;
                    w_last_grant_d = 1'(c_M_DMA);
                end
            end
            default: begin
                w_state_d = ST_IDLE;
            end
        endcase
    end

    // Arbiter state register; reset leaves master 0 favoured for the first tie.
    always_ff @(posedge wb_clk_i) begin
        if (wb_rst_i) begin
            r_state_q      <= ST_IDLE;
            r_last_grant_q <= 1'(c_M_DMA);
        end else begin
            r_state_q      <= w_state_d;
            r_last_grant_q <= w_last_grant_d;
        end
    end

    assign w_own0 = (r_state_q == ST_GNT0);
    assign w_own1 = (r_state_q == ST_GNT1);
    assign gnt_o  = f_gnt_onehot(r_state_q);

    // Forward path: the owner's request drives the slave bus, idle bus is all zero.
    always_comb begin
        s_cyc_o = 1'b0;
        s_stb_o = 1'b0;
        s_we_o  = 1'b0;
        s_sel_o = 4'h0;
        s_adr_o = 32'h0;
        s_dat_o = 32'h0;
        case (r_state_q)
            ST_GNT0: begin
                s_cyc_o = m0_cyc_i;
                s_stb_o = m0_stb_i;
                s_we_o  = m0_we_i;
                s_sel_o = m0_sel_i;
                s_adr_o = m0_adr_i;
                s_dat_o = m0_dat_i;
            end
            ST_GNT1: begin
                s_cyc_o = m1_cyc_i;
                s_stb_o = m1_stb_i;
                s_we_o  = m1_we_i;
                s_sel_o = m1_sel_i;
                s_adr_o = m1_adr_i;
                s_dat_o = m1_dat_i;
            end
            default: begin
                s_cyc_o = 1'b0;
            end
        endcase
    end

    // Watchdog on the muxed strobe; leaving a grant drops s_stb_o and clears it.
    wb_bus_timeout #(
        .TIMEOUT_CYCLES (TIMEOUT_CYCLES),
        .TIMEOUT_W      (TIMEOUT_W)
    ) u_timeout (
        .clk       (wb_clk_i),
        .rst       (wb_rst_i),
        .i_stb     (s_stb_o),
        .i_ack     (s_ack_i),
        .i_err     (s_err_i),
        .o_tmo_hit (w_tmo_hit)
    );

    // Return path: read data is broadcast, terminations go to the owner only,
    // and a slave ACK always beats an ERR or a watchdog expiry.
    assign m0_dat_o = s_dat_i;
    assign m1_dat_o = s_dat_i;
    assign m0_ack_o = s_ack_i & w_own0;
    assign m1_ack_o = s_ack_i & w_own1;
    assign m0_err_o = (s_err_i | w_tmo_hit) & w_own0 & ~s_ack_i;
    assign m1_err_o = (s_err_i | w_tmo_hit) & w_own1 & ~s_ack_i;
    assign tmo_o    = w_tmo_hit;

endmodule : wb_master_arbiter
`default_nettype wire

// File: tb/tb_wb_master_arbiter.sv
`default_nettype none
// ============================================================================
//  Module   : tb_wb_master_arbiter
//  Purpose  : Self-checking bench for wb_master_arbiter: directed scenarios
//             with literal expectations, then random masters and slave
//             compared every cycle against a behavioural bus model.
//  Revision : 1.0  initial release
// ============================================================================
module tb_wb_master_arbiter;

    localparam int c_TMO = 16;

    logic        wb_clk_i = 1'b0;
    logic        wb_rst_i;
    logic        m0_cyc_i, m0_stb_i, m0_we_i;
    logic [3:0]  m0_sel_i;
    logic [31:0] m0_adr_i, m0_dat_i, m0_dat_o;
    logic        m0_ack_o, m0_err_o;
    logic        m1_cyc_i, m1_stb_i, m1_we_i;
    logic [3:0]  m1_sel_i;
    logic [31:0] m1_adr_i, m1_dat_i, m1_dat_o;
    logic        m1_ack_o, m1_err_o;
    logic        s_cyc_o, s_stb_o, s_we_o;
    logic [3:0]  s_sel_o;
    logic [31:0] s_adr_o, s_dat_o, s_dat_i;
    logic        s_ack_i, s_err_i;
    logic [1:0]  gnt_o;
    logic        tmo_o;

    always #5 wb_clk_i = ~wb_clk_i;

    wb_master_arbiter #(
        .TIMEOUT_CYCLES (c_TMO),
        .TIMEOUT_W      (8)
    ) dut (
        .wb_clk_i (wb_clk_i), .wb_rst_i (wb_rst_i),
        .m0_cyc_i (m0_cyc_i), .m0_stb_i (m0_stb_i), .m0_we_i (m0_we_i),
        .m0_sel_i (m0_sel_i), .m0_adr_i (m0_adr_i), .m0_dat_i (m0_dat_i),
        .m0_dat_o (m0_dat_o), .m0_ack_o (m0_ack_o), .m0_err_o (m0_err_o),
        .m1_cyc_i (m1_cyc_i), .m1_stb_i (m1_stb_i), .m1_we_i (m1_we_i),
        .m1_sel_i (m1_sel_i), .m1_adr_i (m1_adr_i), .m1_dat_i (m1_dat_i),
        .m1_dat_o (m1_dat_o), .m1_ack_o (m1_ack_o), .m1_err_o (m1_err_o),
        .s_cyc_o  (s_cyc_o),  .s_stb_o  (s_stb_o),  .s_we_o   (s_we_o),
        .s_sel_o  (s_sel_o),  .s_adr_o  (s_adr_o),  .s_dat_o  (s_dat_o),
        .s_dat_i  (s_dat_i),  .s_ack_i  (s_ack_i),  .s_err_i  (s_err_i),
        .gnt_o    (gnt_o),    .tmo_o    (tmo_o)
    );

    int n_checks = 0;
    int n_fail   = 0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h at t=%0t", name, act, exp, $time);
        end
    endtask

    task automatic tick();
        @(posedge wb_clk_i);
        #1;
    endtask

    task automatic at_neg();
        @(negedge wb_clk_i);
    endtask

    // ------------------------------------------------------------------
    // Behavioural model: who owns the bus (-1 = nobody), who owned it last,
    // and how long the current run of unanswered strobes has been.
    // ------------------------------------------------------------------
    int own    = -1;
    int last   = 1;
    int run    = 0;
    bit chk_en = 1'b0;

    function automatic logic own_stb();
        if (own == 0) return m0_stb_i;
        if (own == 1) return m1_stb_i;
        return 1'b0;
    endfunction

    function automatic logic own_cyc();
        if (own == 0) return m0_cyc_i;
        if (own == 1) return m1_cyc_i;
        return 1'b0;
    endfunction

    function automatic bit unanswered();
        return own_stb() && !s_ack_i && !s_err_i;
    endfunction

    // The c_TMO-th unanswered strobe in a row is the one that times out.
    function automatic bit expiry();
        return unanswered() && (run == c_TMO - 1);
    endfunction

    // Advance the model at every rising edge.
    always @(posedge wb_clk_i) begin : p_model
        if (wb_rst_i) begin
            own    = -1;
            last   = 1;
            run    = 0;
            chk_en = 1'b1;
        end else begin
            run = (unanswered() && !expiry()) ? run + 1 : 0;
            if (own < 0) begin
                if (m0_cyc_i && m1_cyc_i) own = 1 - last;
                else if (m0_cyc_i)        own = 0;
                else if (m1_cyc_i)        own = 1;
            end else if (!own_cyc()) begin
                last = own;
                own  = -1;
            end
        end
    end

    // Compare every DUT output against the model once per cycle.
    always @(negedge wb_clk_i) begin : p_cmp
        logic [31:0] e_adr, e_dat;
        logic [3:0]  e_sel;
        logic        e_cyc, e_stb, e_we, hit;
        logic [1:0]  e_gnt;
        if (chk_en) begin
            e_cyc = 1'b0; e_stb = 1'b0; e_we = 1'b0; e_sel = 4'h0; e_adr = 32'h0; e_dat = 32'h0;
            e_gnt = 2'b00;
            if (own == 0) begin
                e_cyc = m0_cyc_i; e_stb = m0_stb_i; e_we = m0_we_i;
                e_sel = m0_sel_i; e_adr = m0_adr_i; e_dat = m0_dat_i; e_gnt = 2'b01;
            end else if (own == 1) begin
                e_cyc = m1_cyc_i; e_stb = m1_stb_i; e_we = m1_we_i;
                e_sel = m1_sel_i; e_adr = m1_adr_i; e_dat = m1_dat_i; e_gnt = 2'b10;
            end
            hit = expiry();
            chk("gnt",     64'(gnt_o),   64'(e_gnt));
            chk("s_cyc",   64'(s_cyc_o), 64'(e_cyc));
            chk("s_stb",   64'(s_stb_o), 64'(e_stb));
            chk("s_we",    64'(s_we_o),  64'(e_we));
            chk("s_sel",   64'(s_sel_o), 64'(e_sel));
            chk("s_adr",   64'(s_adr_o), 64'(e_adr));
            chk("s_dat",   64'(s_dat_o), 64'(e_dat));
            chk("m0_dat",  64'(m0_dat_o), 64'(s_dat_i));
            chk("m1_dat",  64'(m1_dat_o), 64'(s_dat_i));
            chk("m0_ack",  64'(m0_ack_o), 64'(s_ack_i && own == 0));
            chk("m1_ack",  64'(m1_ack_o), 64'(s_ack_i && own == 1));
            chk("m0_err",  64'(m0_err_o), 64'((s_err_i || hit) && own == 0 && !s_ack_i));
            chk("m1_err",  64'(m1_err_o), 64'((s_err_i || hit) && own == 1 && !s_ack_i));
            chk("tmo",     64'(tmo_o),    64'(hit));
        end
    end

    // Terminations seen by each master this cycle, used only to pace the stimulus.
    bit term[2];
    always @(negedge wb_clk_i) begin : p_term
        term[0] = m0_ack_o | m0_err_o;
        term[1] = m1_ack_o | m1_err_o;
    end

    // Random master state.
    bit          mc[2];
    int          mb[2];
    logic [31:0] ma[2], md[2];
    logic [3:0]  ms[2];
    logic        mw[2];

    initial begin : p_main
        bit mode;
        wb_rst_i = 1'b1;
        m0_cyc_i = 1'b1; m0_stb_i = 1'b1; m0_we_i = 1'b0; m0_sel_i = 4'hF;
        m0_adr_i = 32'h0010_0004; m0_dat_i = 32'h0;
        m1_cyc_i = 1'b1; m1_stb_i = 1'b1; m1_we_i = 1'b0; m1_sel_i = 4'hF;
        m1_adr_i = 32'h2000_0000; m1_dat_i = 32'h0;
        s_dat_i  = 32'h0; s_ack_i = 1'b0; s_err_i = 1'b0;

        // Requests held during reset must not be granted.
        repeat (3) begin
            at_neg();
            chk("rst_gnt",   64'(gnt_o),   64'(2'b00));
            chk("rst_s_cyc", 64'(s_cyc_o), 64'(1'b0));
            chk("rst_terms", 64'({m0_ack_o, m0_err_o, m1_ack_o, m1_err_o, tmo_o}), 64'(5'b0));
        end

        // m0 single read: request in cycle N, grant in N+1, ACK in N+3.
        tick(); wb_rst_i = 1'b0; m1_cyc_i = 1'b0; m1_stb_i = 1'b0;
        at_neg(); chk("first_cycle_gnt", 64'(gnt_o), 64'(2'b00));
        tick(); at_neg();
        chk("rd_gnt",   64'(gnt_o),   64'(2'b01));
        chk("rd_s_adr", 64'(s_adr_o), 64'(32'h0010_0004));
        chk("rd_s_cyc", 64'(s_cyc_o), 64'(1'b1));
        tick(); at_neg(); chk("rd_no_ack_yet", 64'(m0_ack_o), 64'(1'b0));
        tick(); s_ack_i = 1'b1; s_dat_i = 32'hDEAD_BEEF;
        at_neg();
        chk("rd_m0_ack", 64'(m0_ack_o), 64'(1'b1));
        chk("rd_m0_dat", 64'(m0_dat_o), 64'(32'hDEAD_BEEF));
        chk("rd_m1_ack", 64'(m1_ack_o), 64'(1'b0));
        tick(); s_ack_i = 1'b0; m0_cyc_i = 1'b0; m0_stb_i = 1'b0;
        at_neg(); tick(); at_neg(); chk("rd_release_gnt", 64'(gnt_o), 64'(2'b00));

        // Round-robin with both masters requesting, starting from reset.
        tick(); wb_rst_i = 1'b1;
        at_neg(); tick(); wb_rst_i = 1'b0;
        for (int r = 0; r < 4; r++) begin
            tick(); m0_cyc_i = 1'b1; m1_cyc_i = 1'b1;
            for (int k = 0; k < 6; k++) begin
                at_neg();
                if (gnt_o !== 2'b00) break;
                tick();
            end
            chk("rr_gnt", 64'(gnt_o), (r % 2 == 0) ? 64'(2'b01) : 64'(2'b10));
            tick(); m0_cyc_i = 1'b0; m1_cyc_i = 1'b0;
            at_neg(); tick(); at_neg();
        end

        // m1 burst holds the bus against a pending m0 request.
        tick(); m1_cyc_i = 1'b1; m1_stb_i = 1'b1; m1_we_i = 1'b1; m1_sel_i = 4'h3;
        m1_adr_i = 32'h0004_0000; m1_dat_i = 32'h1234_5678;
        for (int k = 0; k < 6; k++) begin
            at_neg();
            if (gnt_o === 2'b10) break;
            tick();
        end
        chk("burst_start_gnt", 64'(gnt_o), 64'(2'b10));
        for (int b = 0; b < 4; b++) begin
            tick();
            m0_cyc_i = 1'b1; m0_stb_i = 1'b1; m0_adr_i = 32'h0010_0008;
            m1_adr_i = 32'h0004_0000 + 32'(b * 4); s_ack_i = 1'b1;
            at_neg();
            chk("burst_gnt",    64'(gnt_o),    64'(2'b10));
            chk("burst_m0_ack", 64'(m0_ack_o), 64'(1'b0));
            chk("burst_m1_ack", 64'(m1_ack_o), 64'(1'b1));
            chk("burst_adr",    64'(s_adr_o),  64'(32'h0004_0000 + 32'(b * 4)));
        end
        tick(); m1_cyc_i = 1'b0; m1_stb_i = 1'b0; s_ack_i = 1'b0;
        at_neg(); chk("burst_end_gnt", 64'(gnt_o), 64'(2'b10));
        tick(); at_neg(); chk("burst_gap_gnt", 64'(gnt_o), 64'(2'b00));

        // m0 strobes into a silent slave: expiry on strobe 16 and 32, then
        // a slave ACK on the 16th strobe of the third run wins over expiry.
        for (int i = 1; i <= 48; i++) begin
            tick(); s_ack_i = (i == 48);
            at_neg();
            if (i == 1) chk("tmo_first_gnt", 64'(gnt_o), 64'(2'b01));
            chk("tmo_m0_err", 64'(m0_err_o), 64'(i == 16 || i == 32));
            chk("tmo_pulse",  64'(tmo_o),    64'(i == 16 || i == 32));
            chk("tmo_m0_ack", 64'(m0_ack_o), 64'(i == 48));
        end
        chk("model_owner", 64'(own), 64'(0));
        chk("model_run",   64'(run), 64'(15));

        // Reset in the middle of a granted strobe clears the bus next cycle.
        tick(); s_ack_i = 1'b0; wb_rst_i = 1'b1;
        at_neg(); chk("midrst_still_gnt", 64'(gnt_o), 64'(2'b01));
        tick(); at_neg();
        chk("midrst_gnt",   64'(gnt_o),   64'(2'b00));
        chk("midrst_s_bus", 64'({s_cyc_o, s_stb_o, s_we_o, s_sel_o, s_adr_o[31:0]}), 64'(0));
        chk("midrst_terms", 64'({m0_ack_o, m0_err_o, tmo_o}), 64'(3'b0));
        tick(); wb_rst_i = 1'b0; m0_cyc_i = 1'b0; m0_stb_i = 1'b0; m0_we_i = 1'b0; m1_we_i = 1'b0;

        // Random traffic: bursty masters, slave alternating responsive and sluggish.
        for (int x = 0; x < 2; x++) begin
            mc[x] = 1'b0; mb[x] = 0; ma[x] = 32'h0; md[x] = 32'h0; ms[x] = 4'h0; mw[x] = 1'b0;
        end
        for (int c = 0; c < 3200; c++) begin
            tick();
            mode = ((c / 400) % 2) == 1;
            for (int x = 0; x < 2; x++) begin
                if (!mc[x]) begin
                    if ($urandom_range(3) == 0) begin
                        mc[x] = 1'b1; mb[x] = int'($urandom_range(4, 1));
                        ma[x] = $urandom; md[x] = $urandom;
                        ms[x] = 4'($urandom); mw[x] = 1'($urandom);
                    end
                end else if ($urandom_range(99) == 0) begin
                    mc[x] = 1'b0;
                end else if (term[x]) begin
                    mb[x]--;
                    if (mb[x] <= 0) mc[x] = 1'b0;
                    else begin ma[x] = $urandom; md[x] = $urandom; end
                end
            end
            m0_cyc_i = mc[0]; m0_stb_i = mc[0]; m0_we_i = mw[0];
            m0_sel_i = ms[0]; m0_adr_i = ma[0]; m0_dat_i = md[0];
            m1_cyc_i = mc[1]; m1_stb_i = mc[1]; m1_we_i = mw[1];
            m1_sel_i = ms[1]; m1_adr_i = ma[1]; m1_dat_i = md[1];
            s_dat_i  = $urandom;
            if (!mode) begin
                s_ack_i = ($urandom_range(1) == 0);
                s_err_i = ($urandom_range(15) == 0);
            end else begin
                s_ack_i = ($urandom_range(39) == 0);
                s_err_i = 1'b0;
            end
        end

        tick();
        m0_cyc_i = 1'b0; m0_stb_i = 1'b0; m1_cyc_i = 1'b0; m1_stb_i = 1'b0;
        s_ack_i = 1'b0; s_err_i = 1'b0;
        repeat (3) tick();
        at_neg();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule : tb_wb_master_arbiter
`default_nettype wire
